// File: rtl/pong_pkg.sv
// Shared widths, state encoding and score helper for the pong referee slice.
package pong_pkg;

    localparam int COORD_W = 12;
    localparam int SCORE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_SCORE = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] lim);
        return (s >= lim) ? lim : s + 1'b1;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational overlap test of two axis-aligned boxes (inclusive edges, unsigned).
module box_overlap
    import pong_pkg::*;
(
    input  logic [COORD_W-1:0] a_x1,
    input  logic [COORD_W-1:0] a_x2,
    input  logic [COORD_W-1:0] a_y1,
    input  logic [COORD_W-1:0] a_y2,
    input  logic [COORD_W-1:0] b_x1,
    input  logic [COORD_W-1:0] b_x2,
    input  logic [COORD_W-1:0] b_y1,
    input  logic [COORD_W-1:0] b_y2,
    output logic               overlap
);

    assign overlap = (a_x1 <= b_x2) && (a_x2 >= b_x1) &&
                     (a_y1 <= b_y2) && (a_y2 >= b_y1);

endmodule

// File: rtl/pong_referee.sv
// Pong referee: paddle hit/miss detection, scoring and game sequencing.
// Optional pause input enabled by defining REFEREE_PAUSE_EN.
module pong_referee
    import pong_pkg::*;
#(
    parameter int D_WIDTH     = 639,
    parameter int MISS_MARGIN = 6,
    parameter int SCORE_MAX   = 9,
    parameter int SERVE_DELAY = 60,
    parameter int HIT_HOLDOFF = 8
) (
    input  logic               in_clock,
    input  logic               in_reset_n,
    input  logic               in_ani_stb,
    input  logic               in_start,
`ifdef REFEREE_PAUSE_EN
    input  logic               in_pause,
`endif
    input  logic [COORD_W-1:0] in_ball_x1,
    input  logic [COORD_W-1:0] in_ball_x2,
    input  logic [COORD_W-1:0] in_ball_y1,
    input  logic [COORD_W-1:0] in_ball_y2,
    input  logic [COORD_W-1:0] in_padl_x1,
    input  logic [COORD_W-1:0] in_padl_x2,
    input  logic [COORD_W-1:0] in_padl_y1,
    input  logic [COORD_W-1:0] in_padl_y2,
    input  logic [COORD_W-1:0] in_padr_x1,
    input  logic [COORD_W-1:0] in_padr_x2,
    input  logic [COORD_W-1:0] in_padr_y1,
    input  logic [COORD_W-1:0] in_padr_y2,
    output logic               out_obj_reset,
    output logic               out_animate,
    output logic               out_hit_l,
    output logic               out_hit_r,
    output logic [SCORE_W-1:0] out_score_l,
    output logic [SCORE_W-1:0] out_score_r,
    output logic [2:0]         out_state,
    output logic               out_game_over
);

    localparam int SRV_W  = $clog2(SERVE_DELAY + 1);
    localparam int HOLD_W = $clog2(HIT_HOLDOFF + 1);
    localparam logic [SRV_W-1:0]   SRV_LAST  = SRV_W'(SERVE_DELAY - 1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HIT_HOLDOFF);
    localparam logic [SCORE_W-1:0] SMAX      = SCORE_W'(SCORE_MAX);

    state_t             state;
    logic [SRV_W-1:0]   serve_cnt;
    logic [HOLD_W-1:0]  holdoff;
    logic               scorer_r;
    logic               ov_l, ov_r;
    logic               hit_ok, miss_l, miss_r;
    logic [SCORE_W-1:0] inc_l, inc_r;
    logic               reach_max;

    box_overlap u_ov_l (
        .a_x1(in_ball_x1), .a_x2(in_ball_x2), .a_y1(in_ball_y1), .a_y2(in_ball_y2),
        .b_x1(in_padl_x1), .b_x2(in_padl_x2), .b_y1(in_padl_y1), .b_y2(in_padl_y2),
        .overlap(ov_l)
    );

    box_overlap u_ov_r (
        .a_x1(in_ball_x1), .a_x2(in_ball_x2), .a_y1(in_ball_y1), .a_y2(in_ball_y2),
        .b_x1(in_padr_x1), .b_x2(in_padr_x2), .b_y1(in_padr_y1), .b_y2(in_padr_y2),
        .overlap(ov_r)
    );

    // x1 above the display width means the ball wrapped past the left wall.
    assign miss_l    = (in_ball_x1 <= COORD_W'(MISS_MARGIN)) || (in_ball_x1 > COORD_W'(D_WIDTH));
    assign miss_r    = in_ball_x2 >= COORD_W'(D_WIDTH - MISS_MARGIN);
    assign hit_ok    = (holdoff == '0);
    assign inc_l     = sat_inc(out_score_l, SMAX);
    assign inc_r     = sat_inc(out_score_r, SMAX);
    assign reach_max = scorer_r ? (inc_r == SMAX) : (inc_l == SMAX);
    assign out_state = state;

`ifdef REFEREE_PAUSE_EN
    logic pause_q;
    logic pause_rise;
    assign pause_rise = in_pause && !pause_q;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) pause_q <= 1'b0;
        else             pause_q <= in_pause;
    end
`endif

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state         <= ST_IDLE;
            out_obj_reset <= 1'b1;
            out_animate   <= 1'b0;
            out_hit_l     <= 1'b0;
            out_hit_r     <= 1'b0;
            out_score_l   <= '0;
            out_score_r   <= '0;
            out_game_over <= 1'b0;
            serve_cnt     <= '0;
            holdoff       <= '0;
            scorer_r      <= 1'b0;
        end else begin
            out_hit_l <= 1'b0;
            out_hit_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    out_obj_reset <= 1'b1;
                    out_animate   <= 1'b0;
                    out_game_over <= 1'b0;
                    if (in_start) state <= ST_SERVE;
                end
                ST_SERVE: begin
                    out_obj_reset <= 1'b0;
                    if (in_ani_stb) begin
                        if (serve_cnt == SRV_LAST) begin
                            serve_cnt   <= '0;
                            state       <= ST_PLAY;
                            out_animate <= 1'b1;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
`ifdef REFEREE_PAUSE_EN
                    if (pause_rise) begin
                        state       <= ST_PAUSE;
                        out_animate <= 1'b0;
                    end else
`endif
                    if (in_ani_stb) begin
                        if (hit_ok && ov_l) begin
                            out_hit_l <= 1'b1;
                            holdoff   <= HOLD_INIT;
                        end else if (hit_ok && ov_r) begin
                            out_hit_r <= 1'b1;
                            holdoff   <= HOLD_INIT;
                        end else begin
                            if (holdoff != '0) holdoff <= holdoff - 1'b1;
                            if (miss_l || miss_r) begin
                                scorer_r    <= miss_l;
                                state       <= ST_SCORE;
                                out_animate <= 1'b0;
                            end
                        end
                    end
                end
                ST_SCORE: begin
                    if (scorer_r) out_score_r <= inc_r;
                    else          out_score_l <= inc_l;
                    if (reach_max) begin
                        state         <= ST_OVER;
                        out_game_over <= 1'b1;
                    end else begin
                        state         <= ST_SERVE;
                        out_obj_reset <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (in_start) begin
                        out_score_l   <= '0;
                        out_score_r   <= '0;
                        out_game_over <= 1'b0;
                        out_obj_reset <= 1'b1;
                        state         <= ST_SERVE;
                    end
                end
`ifdef REFEREE_PAUSE_EN
                ST_PAUSE: begin
                    if (pause_rise) begin
                        state       <= ST_PLAY;
                        out_animate <= 1'b1;
                    end
                end
`endif
                default: begin
                    state         <= ST_IDLE;
                    out_obj_reset <= 1'b1;
                    out_animate   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_referee.sv
// Scoreboard bench for pong_referee: a rule-level game model queues expected outputs per clock.
module tb_pong_referee;

    localparam int D_WIDTH     = 639;
    localparam int MISS_MARGIN = 6;
    localparam int SCORE_MAX   = 9;
    localparam int SERVE_DELAY = 60;
    localparam int HIT_HOLDOFF = 8;

    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_SCORE = 3, P_OVER = 4;

    logic        in_clock, in_reset_n, in_ani_stb, in_start;
    logic [11:0] b_x1, b_x2, b_y1, b_y2;
    logic [11:0] l_x1, l_x2, l_y1, l_y2;
    logic [11:0] r_x1, r_x2, r_y1, r_y2;
    logic        out_obj_reset, out_animate, out_hit_l, out_hit_r, out_game_over;
    logic [3:0]  out_score_l, out_score_r;
    logic [2:0]  out_state;
`ifdef REFEREE_PAUSE_EN
    logic        in_pause;
    initial in_pause = 1'b0;
`endif

    pong_referee #(
        .D_WIDTH(D_WIDTH), .MISS_MARGIN(MISS_MARGIN), .SCORE_MAX(SCORE_MAX),
        .SERVE_DELAY(SERVE_DELAY), .HIT_HOLDOFF(HIT_HOLDOFF)
    ) dut (
        .in_clock(in_clock), .in_reset_n(in_reset_n), .in_ani_stb(in_ani_stb), .in_start(in_start),
`ifdef REFEREE_PAUSE_EN
        .in_pause(in_pause),
`endif
        .in_ball_x1(b_x1), .in_ball_x2(b_x2), .in_ball_y1(b_y1), .in_ball_y2(b_y2),
        .in_padl_x1(l_x1), .in_padl_x2(l_x2), .in_padl_y1(l_y1), .in_padl_y2(l_y2),
        .in_padr_x1(r_x1), .in_padr_x2(r_x2), .in_padr_y1(r_y1), .in_padr_y2(r_y2),
        .out_obj_reset(out_obj_reset), .out_animate(out_animate),
        .out_hit_l(out_hit_l), .out_hit_r(out_hit_r),
        .out_score_l(out_score_l), .out_score_r(out_score_r),
        .out_state(out_state), .out_game_over(out_game_over)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // Game model: phase, scores, serve strobes seen, play strobes since last hit.
    int m_ph, m_sc_l, m_sc_r, m_srv, m_since;
    bit m_scorer_r, m_ores, m_anim, m_hl, m_hr, m_over;

    function automatic bit boxes_touch(int ax1, int ax2, int ay1, int ay2,
                                       int bx1, int bx2, int by1, int by2);
        return (ax1 <= bx2) && (ax2 >= bx1) && (ay1 <= by2) && (ay2 >= by1);
    endfunction

    function automatic int bump(int s);
        return (s + 1 > SCORE_MAX) ? SCORE_MAX : s + 1;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_sc_l = 0; m_sc_r = 0; m_srv = 0; m_since = HIT_HOLDOFF;
        m_scorer_r = 0; m_ores = 1; m_anim = 0; m_hl = 0; m_hr = 0; m_over = 0;
    endtask

    task automatic model_step();
        bit tl, tr, elig, ml, mr;
        if (!in_reset_n) begin
            model_reset();
            return;
        end
        m_hl = 0; m_hr = 0;
        case (m_ph)
            P_IDLE: begin
                m_ores = 1; m_anim = 0; m_over = 0;
                if (in_start) m_ph = P_SERVE;
            end
            P_SERVE: begin
                m_ores = 0;
                if (in_ani_stb) begin
                    m_srv++;
                    if (m_srv == SERVE_DELAY) begin
                        m_srv = 0; m_ph = P_PLAY; m_anim = 1;
                    end
                end
            end
            P_PLAY: if (in_ani_stb) begin
                tl   = boxes_touch(b_x1, b_x2, b_y1, b_y2, l_x1, l_x2, l_y1, l_y2);
                tr   = boxes_touch(b_x1, b_x2, b_y1, b_y2, r_x1, r_x2, r_y1, r_y2);
                elig = (m_since >= HIT_HOLDOFF);
                ml   = (int'(b_x1) <= MISS_MARGIN) || (int'(b_x1) > D_WIDTH);
                mr   = int'(b_x2) >= D_WIDTH - MISS_MARGIN;
                if (elig && tl) begin
                    m_hl = 1; m_since = 0;
                end else if (elig && tr) begin
                    m_hr = 1; m_since = 0;
                end else begin
                    m_since++;
                    if (ml || mr) begin
                        m_scorer_r = ml; m_ph = P_SCORE; m_anim = 0;
                    end
                end
            end
            P_SCORE: begin
                if (m_scorer_r) m_sc_r = bump(m_sc_r);
                else            m_sc_l = bump(m_sc_l);
                if ((m_scorer_r ? m_sc_r : m_sc_l) == SCORE_MAX) begin
                    m_ph = P_OVER; m_over = 1;
                end else begin
                    m_ph = P_SERVE; m_ores = 1;
                end
            end
            P_OVER: if (in_start) begin
                m_sc_l = 0; m_sc_r = 0; m_over = 0; m_ores = 1; m_ph = P_SERVE;
            end
            default: ;
        endcase
    endtask

    function automatic logic [15:0] exp_vec();
        return {3'(m_ph), m_ores, m_anim, m_hl, m_hr, 4'(m_sc_l), 4'(m_sc_r), m_over};
    endfunction

    task automatic cycle();
        @(posedge in_clock);
        #1;
        model_step();
        exp_q.push_back(exp_vec());
    endtask

    task automatic set_ball(int x1, int x2, int y1, int y2);
        b_x1 = 12'(x1); b_x2 = 12'(x2); b_y1 = 12'(y1); b_y2 = 12'(y2);
    endtask

    task automatic random_ball();
        int c, x, y;
        c = $urandom_range(0, 99);
        y = $urandom_range(0, 460);
        if (c < 40) begin
            x = $urandom_range(60, 560); set_ball(x, x + 20, y, y + 20);
        end else if (c < 45) begin
            set_ball(7, 27, y, y + 20);
        end else if (c < 60) begin
            x = $urandom_range(0, 20); y = $urandom_range(int'(l_y1) - 10, int'(l_y2));
            set_ball(x, x + 20, y, y + 20);
        end else if (c < 75) begin
            x = $urandom_range(600, 625); y = $urandom_range(int'(r_y1) - 10, int'(r_y2));
            set_ball(x, x + 20, y, y + 20);
        end else if (c < 85) begin
            x = $urandom_range(0, 6); set_ball(x, x + 20, y, y + 20);
        end else if (c < 88) begin
            x = $urandom_range(640, 4095); set_ball(x, (x + 20) % 4096, y, y + 20);
        end else if (c < 98) begin
            x = $urandom_range(633, 639); set_ball(x - 20, x, y, y + 20);
        end else begin
            set_ball(612, 632, y, y + 20);
        end
    endtask

    // Monitor: one expected output word per clock, compared mid-cycle.
    initial begin
        logic [15:0] e, a;
        forever begin
            @(negedge in_clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {out_state, out_obj_reset, out_animate, out_hit_l, out_hit_r,
                     out_score_l, out_score_r, out_game_over};
                checks++;
                if (a !== e)
                    begin
                    errors++;
                    $display("FAIL outputs t=%0t got st=%0d ores=%b anim=%b hl=%b hr=%b sl=%0d sr=%0d over=%b want st=%0d ores=%b anim=%b hl=%b hr=%b sl=%0d sr=%0d over=%b",
                             $time, a[15:13], a[12], a[11], a[10], a[9], a[8:5], a[4:1], a[0],
                             e[15:13], e[12], e[11], e[10], e[9], e[8:5], e[4:1], e[0]);
                end
            end
        end
    end

    initial begin
        int waited;
        in_reset_n = 1'b0; in_ani_stb = 1'b0; in_start = 1'b0;
        set_ball(300, 320, 240, 260);
        l_x1 = 12'd0;   l_x2 = 12'd20;  l_y1 = 12'd150; l_y2 = 12'd330;
        r_x1 = 12'd619; r_x2 = 12'd639; r_y1 = 12'd100; r_y2 = 12'd220;
        model_reset();

        cycle(); cycle();
        in_reset_n = 1'b1;
        cycle();
        in_start = 1'b1;
        cycle();
        in_start = 1'b0;

        // Serve countdown with alternating strobes, ball parked mid-field.
        for (int i = 0; i < 130; i++) begin
            in_ani_stb = (i % 2 == 0);
            cycle();
        end

        // Sustained left-paddle overlap: hit, holdoff, hit again.
        set_ball(20, 40, 200, 220);
        for (int i = 0; i < 24; i++) begin
            in_ani_stb = (i % 2 == 0);
            cycle();
        end

        // Left wall miss while holdoff is still active.
        set_ball(4, 24, 400, 420);
        for (int i = 0; i < 6; i++) begin
            in_ani_stb = (i % 2 == 0);
            cycle();
        end

        // Randomised play including wrap, priority and game-over cases.
        for (int i = 0; i < 12000; i++) begin
            in_ani_stb = !in_ani_stb && ($urandom_range(0, 1) == 1);
            in_start   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                l_y1 = 12'($urandom_range(20, 300)); l_y2 = l_y1 + 12'd120;
                r_y1 = 12'($urandom_range(20, 300)); r_y2 = r_y1 + 12'd120;
            end
            random_ball();
            cycle();
        end

        // Drive into PLAY, then pull reset between clock edges.
        waited = 0;
        set_ball(300, 320, 240, 260);
        while (m_ph != P_PLAY && waited < 2000) begin
            in_ani_stb = !in_ani_stb;
            in_start   = 1'b1;
            cycle();
            waited++;
        end
        in_start = 1'b0; in_ani_stb = 1'b0;
        checks++;
        if (m_ph != P_PLAY) begin
            errors++;
            $display("FAIL reach_play got phase=%0d want=%0d", m_ph, P_PLAY);
        end
        @(posedge in_clock);
        #1;
        in_reset_n = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(exp_vec());
        cycle(); cycle();
        in_reset_n = 1'b1;
        cycle(); cycle();

        @(negedge in_clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
